// File: rtl/ping_pong_merger.sv
`default_nettype none
// ============================================================================
// Module   : ping_pong_merger
// Brief    : Re-interleaves two packetized 512-bit streams into one frame
//            stream, alternating groups of PACKETS_PER_GROUP packets.
//            Optional packet-length checker: PING_PONG_MERGER_PKT_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ping_pong_merger (
    input  logic         clk,
    input  logic         resetn,
    input  logic [511:0] AXIS_IN0_TDATA,
    input  logic         AXIS_IN0_TLAST,
    input  logic         AXIS_IN0_TVALID,
    output logic         AXIS_IN0_TREADY,
    input  logic [511:0] AXIS_IN1_TDATA,
    input  logic         AXIS_IN1_TLAST,
    input  logic         AXIS_IN1_TVALID,
    output logic         AXIS_IN1_TREADY,
    output logic [511:0] AXIS_OUT_TDATA,
    output logic         AXIS_OUT_TLAST,
    output logic         AXIS_OUT_TVALID,
    input  logic         AXIS_OUT_TREADY,
    input  logic [31:0]  PACKETS_PER_GROUP,
    input  logic [15:0]  PACKET_SIZE,
    output logic         PKT_ERR
);

    logic         r_input_select;
    logic [31:0]  r_packet_counter;
    logic         r_out_full;
    logic [511:0] r_out_data;
    logic         r_out_last;

    logic         w_accept_ok;
    logic         w_in_fire;
    logic         w_in_last;
    logic [511:0] w_in_data;
    logic         w_out_fire;
    logic [31:0]  w_group_size;
    logic         w_unused_packet_size;

    assign w_accept_ok     = !r_out_full | AXIS_OUT_TREADY;
    assign AXIS_IN0_TREADY = resetn & w_accept_ok & !r_input_select;
    assign AXIS_IN1_TREADY = resetn & w_accept_ok &  r_input_select;

    assign w_in_fire  = r_input_select ? (AXIS_IN1_TVALID & AXIS_IN1_TREADY)
                                       : (AXIS_IN0_TVALID & AXIS_IN0_TREADY);
    assign w_in_last  = r_input_select ? AXIS_IN1_TLAST : AXIS_IN0_TLAST;
    assign w_in_data  = r_input_select ? AXIS_IN1_TDATA : AXIS_IN0_TDATA;
    assign w_out_fire = r_out_full & AXIS_OUT_TREADY;

    // A group size of zero behaves as one packet per group.
    assign w_group_size = (PACKETS_PER_GROUP == 32'd0) ? 32'd1 : PACKETS_PER_GROUP;

    assign AXIS_OUT_TDATA  = r_out_data;
    assign AXIS_OUT_TLAST  = r_out_last;
    assign AXIS_OUT_TVALID = r_out_full;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_input_select   <= 1'b0;
            r_packet_counter <= 32'd1;
            r_out_full       <= 1'b0;
            r_out_data       <= '0;
            r_out_last       <= 1'b0;
        end else begin
            // A load in the same cycle as a drain replaces the beat and keeps the stage full.
            if (w_in_fire) begin
                r_out_full <= 1'b1;
                r_out_data <= w_in_data;
                r_out_last <= w_in_last;
            end else if (w_out_fire) begin
                r_out_full <= 1'b0;
            end

            if (w_in_fire && w_in_last) begin
                if (r_packet_counter < w_group_size) begin
                    r_packet_counter <= r_packet_counter + 32'd1;
                end else begin
                    r_packet_counter <= 32'd1;
                    r_input_select   <= !r_input_select;
                end
            end
        end
    end

    assign w_unused_packet_size = ^PACKET_SIZE;

`ifdef PING_PONG_MERGER_PKT_CHECK_EN
    logic [15:0] r_beat_count;
    logic        r_pkt_err;
    logic [15:0] w_beats_per_pkt;

    assign w_beats_per_pkt = {6'd0, PACKET_SIZE[15:6]};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_beat_count <= 16'd1;
            r_pkt_err    <= 1'b0;
        end else if (w_in_fire) begin
            if (w_in_last) begin
                if (r_beat_count < w_beats_per_pkt) begin
                    r_pkt_err <= 1'b1;
                end
                r_beat_count <= 16'd1;
            end else begin
                if (r_beat_count == w_beats_per_pkt) begin
                    r_pkt_err <= 1'b1;
                end
                r_beat_count <= r_beat_count + 16'd1;
            end
        end
    end

    assign PKT_ERR = r_pkt_err;
`else
    assign PKT_ERR = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ping_pong_merger.sv
`default_nettype none
// ============================================================================
// Module   : tb_ping_pong_merger
// Brief    : Scoreboard bench for ping_pong_merger; expected interleave queued
//            by stimulus, popped by an independent output monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ping_pong_merger;

    logic         clk;
    logic         resetn;
    logic [511:0] AXIS_IN0_TDATA;
    logic         AXIS_IN0_TLAST;
    logic         AXIS_IN0_TVALID;
    logic         AXIS_IN0_TREADY;
    logic [511:0] AXIS_IN1_TDATA;
    logic         AXIS_IN1_TLAST;
    logic         AXIS_IN1_TVALID;
    logic         AXIS_IN1_TREADY;
    logic [511:0] AXIS_OUT_TDATA;
    logic         AXIS_OUT_TLAST;
    logic         AXIS_OUT_TVALID;
    logic         AXIS_OUT_TREADY;
    logic [31:0]  PACKETS_PER_GROUP;
    logic [15:0]  PACKET_SIZE;
    logic         PKT_ERR;

    int           n_total = 0;
    int           n_pass  = 0;
    int           cyc     = 0;
    int           hs_cnt  = 0;
    int           hs_first = 0;
    int           hs_last  = 0;
    logic         rand_ready = 1'b0;
    logic [512:0] exp_q[$];

    ping_pong_merger dut (
        .clk               (clk),
        .resetn            (resetn),
        .AXIS_IN0_TDATA    (AXIS_IN0_TDATA),
        .AXIS_IN0_TLAST    (AXIS_IN0_TLAST),
        .AXIS_IN0_TVALID   (AXIS_IN0_TVALID),
        .AXIS_IN0_TREADY   (AXIS_IN0_TREADY),
        .AXIS_IN1_TDATA    (AXIS_IN1_TDATA),
        .AXIS_IN1_TLAST    (AXIS_IN1_TLAST),
        .AXIS_IN1_TVALID   (AXIS_IN1_TVALID),
        .AXIS_IN1_TREADY   (AXIS_IN1_TREADY),
        .AXIS_OUT_TDATA    (AXIS_OUT_TDATA),
        .AXIS_OUT_TLAST    (AXIS_OUT_TLAST),
        .AXIS_OUT_TVALID   (AXIS_OUT_TVALID),
        .AXIS_OUT_TREADY   (AXIS_OUT_TREADY),
        .PACKETS_PER_GROUP (PACKETS_PER_GROUP),
        .PACKET_SIZE       (PACKET_SIZE),
        .PKT_ERR           (PKT_ERR)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [512:0] act, input logic [512:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [511:0] mk(input int s, input int p, input int b);
        logic [31:0] w;
        w = {8'(s), 16'(p), 8'(b)};
        return {16{w}};
    endfunction

    function automatic logic in_ready(input int s);
        return (s != 0) ? AXIS_IN1_TREADY : AXIS_IN0_TREADY;
    endfunction

    task automatic set_in(input int s, input logic v, input logic [511:0] d, input logic l);
        if (s != 0) begin
            AXIS_IN1_TVALID = v; AXIS_IN1_TDATA = d; AXIS_IN1_TLAST = l;
        end else begin
            AXIS_IN0_TVALID = v; AXIS_IN0_TDATA = d; AXIS_IN0_TLAST = l;
        end
    endtask

    task automatic push_pkt(input int s, input int p, input int nb);
        for (int b = 0; b < nb; b++) exp_q.push_back({(b == nb - 1), mk(s, p, b)});
    endtask

    // Sends np packets of nb beats back to back; handshake completes at the posedge following a ready sample.
    task automatic drive_stream(input int s, input int p0, input int np, input int nb);
        for (int p = p0; p < p0 + np; p++) begin
            for (int b = 0; b < nb; b++) begin
                @(negedge clk);
                set_in(s, 1'b1, mk(s, p, b), (b == nb - 1));
                #1;
                while (!in_ready(s)) begin
                    @(negedge clk);
                    #1;
                end
                @(posedge clk);
            end
        end
        @(negedge clk);
        set_in(s, 1'b0, '0, 1'b0);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rand_ready) AXIS_OUT_TREADY = 1'($urandom_range(0, 1));
    end

    // Output monitor: sampled well after the negedge so all bench drives have settled.
    initial begin
        logic         prev_stall;
        logic [512:0] prev_beat;
        logic [512:0] e;
        prev_stall = 1'b0;
        prev_beat  = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!resetn) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && AXIS_OUT_TVALID)
                    check("hold_stable", {AXIS_OUT_TLAST, AXIS_OUT_TDATA}, prev_beat);
                if (AXIS_OUT_TVALID && AXIS_OUT_TREADY) begin
                    if (hs_cnt == 0) hs_first = cyc;
                    hs_last = cyc;
                    hs_cnt++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", {AXIS_OUT_TLAST, AXIS_OUT_TDATA}, '0);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_beat", {AXIS_OUT_TLAST, AXIS_OUT_TDATA}, e);
                    end
                end
                prev_stall = AXIS_OUT_TVALID && !AXIS_OUT_TREADY;
                prev_beat  = {AXIS_OUT_TLAST, AXIS_OUT_TDATA};
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $fatal(1);
    end

    initial begin
        resetn = 1'b0;
        AXIS_OUT_TREADY = 1'b1;
        PACKETS_PER_GROUP = 32'd1;
        PACKET_SIZE = 16'd256;
        set_in(0, 1'b1, '1, 1'b1);
        set_in(1, 1'b1, '1, 1'b1);

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_in0_ready", AXIS_IN0_TREADY, 0);
        check("rst_in1_ready", AXIS_IN1_TREADY, 0);
        check("rst_out_valid", AXIS_OUT_TVALID, 0);
        check("rst_out_last", AXIS_OUT_TLAST, 0);
        check("rst_out_data", AXIS_OUT_TDATA, 0);
        check("rst_pkt_err", PKT_ERR, 0);
        set_in(0, 1'b0, '0, 1'b0);
        set_in(1, 1'b0, '0, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        check("post_rst_in0_ready", AXIS_IN0_TREADY, 1);
        check("post_rst_in1_ready", AXIS_IN1_TREADY, 0);

        // Group of 2, full throughput: 0,0,1,1,0,0,1,1 with no gap
        PACKETS_PER_GROUP = 32'd2;
        PACKET_SIZE = 16'd256;
        hs_cnt = 0;
        for (int g = 0; g < 2; g++)
            for (int s = 0; s < 2; s++)
                for (int p = g * 2; p < g * 2 + 2; p++) push_pkt(s, p, 4);
        fork
            drive_stream(0, 0, 4, 4);
            drive_stream(1, 0, 4, 4);
        join
        drain();
        check("t1_beat_count", hs_cnt, 32);
        check("t1_no_gap", hs_last - hs_first, 31);

        // Group size 0 behaves as 1
        PACKETS_PER_GROUP = 32'd0;
        PACKET_SIZE = 16'd128;
        for (int p = 0; p < 3; p++) begin
            push_pkt(0, p + 3, 2);
            push_pkt(1, p + 3, 2);
        end
        fork
            drive_stream(0, 3, 3, 2);
            drive_stream(1, 3, 3, 2);
        join
        drain();

        // Random output backpressure, group of 3
        PACKETS_PER_GROUP = 32'd3;
        PACKET_SIZE = 16'd192;
        rand_ready = 1'b1;
        for (int g = 0; g < 2; g++)
            for (int s = 0; s < 2; s++)
                for (int p = g * 3; p < g * 3 + 3; p++) push_pkt(s, p + 40, 3);
        fork
            drive_stream(0, 40, 6, 3);
            drive_stream(1, 40, 6, 3);
        join
        drain();
        @(negedge clk);
        rand_ready = 1'b0;
        AXIS_OUT_TREADY = 1'b1;

        // Input 1 valid while input 0 idle: nothing moves until input 0 finishes its group
        PACKETS_PER_GROUP = 32'd1;
        PACKET_SIZE = 16'd128;
        push_pkt(0, 7, 2);
        push_pkt(1, 7, 2);
        fork
            drive_stream(1, 7, 1, 2);
            begin
                repeat (6) begin
                    @(negedge clk);
                    #1;
                    check("idle0_in1_ready", AXIS_IN1_TREADY, 0);
                    check("idle0_out_valid", AXIS_OUT_TVALID, 0);
                end
                drive_stream(0, 7, 1, 2);
            end
        join
        drain();

        // Reset mid-packet on input 1
        PACKET_SIZE = 16'd256;
        push_pkt(0, 9, 4);
        drive_stream(0, 9, 1, 4);
        drain();
        @(negedge clk);
        AXIS_OUT_TREADY = 1'b0;
        set_in(1, 1'b1, mk(1, 9, 0), 1'b0);
        #1;
        check("mid_in1_ready", AXIS_IN1_TREADY, 1);
        @(negedge clk);
        set_in(1, 1'b1, mk(1, 9, 1), 1'b0);
        resetn = 1'b0;
        #1;
        check("mid_rst_in0_ready", AXIS_IN0_TREADY, 0);
        check("mid_rst_in1_ready", AXIS_IN1_TREADY, 0);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        check("mid_rst_out_valid", AXIS_OUT_TVALID, 0);
        set_in(1, 1'b0, '0, 1'b0);
        AXIS_OUT_TREADY = 1'b1;
        push_pkt(0, 10, 4);
        push_pkt(1, 10, 4);
        fork
            drive_stream(0, 10, 1, 4);
            drive_stream(1, 10, 1, 4);
        join
        drain();

        // Short packet: 3 beats against 256-byte packets
        push_pkt(0, 20, 3);
        drive_stream(0, 20, 1, 3);
`ifdef PING_PONG_MERGER_PKT_CHECK_EN
        check("pkt_err_set", PKT_ERR, 1);
`else
        check("pkt_err_tied", PKT_ERR, 0);
`endif
        drain();
        repeat (3) @(negedge clk);
`ifdef PING_PONG_MERGER_PKT_CHECK_EN
        check("pkt_err_sticky", PKT_ERR, 1);
`else
        check("pkt_err_tied_later", PKT_ERR, 0);
`endif
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        #1;
        check("pkt_err_after_rst", PKT_ERR, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ping_pong_merger.md
Name: ping_pong_merger

Overview:
- Receive-side counterpart of the frame ping-ponger: consumes the two packetized 512-bit output streams and re-interleaves them into one frame stream.
- Takes PACKETS_PER_GROUP packets from input 0, then the same number from input 1, and alternates indefinitely.
- A single registered output stage isolates downstream TREADY from both inputs.

Parameters:
- None. Group size is a runtime input.

Ports:
- clk  input  1  system clock
- resetn  input  1  synchronous, active-low reset
- AXIS_IN0_TDATA  input  512  stream 0 data
- AXIS_IN0_TLAST  input  1  stream 0 end-of-packet
- AXIS_IN0_TVALID  input  1  stream 0 valid
- AXIS_IN0_TREADY  output  1  stream 0 ready
- AXIS_IN1_TDATA  input  512  stream 1 data
- AXIS_IN1_TLAST  input  1  stream 1 end-of-packet
- AXIS_IN1_TVALID  input  1  stream 1 valid
- AXIS_IN1_TREADY  output  1  stream 1 ready
- AXIS_OUT_TDATA  output  512  merged data
- AXIS_OUT_TLAST  output  1  passes through the source packet's TLAST
- AXIS_OUT_TVALID  output  1  merged valid
- AXIS_OUT_TREADY  input  1  merged ready
- PACKETS_PER_GROUP  input  32  packets per group; 0 is treated as 1
- PACKET_SIZE  input  16  bytes per packet; used only with the optional feature
- PKT_ERR  output  1  sticky packet-length error

Behaviour:
- Reset (resetn==0 at posedge):
  - input_select=0, packet_counter=1, out_full=0.
  - AXIS_OUT_TVALID=0, AXIS_OUT_TLAST=0, AXIS_OUT_TDATA=0, PKT_ERR=0.
  - Both AXIS_INx_TREADY are combinationally 0 while resetn==0.
- Output register:
  - out_full holds the current output beat; AXIS_OUT_TVALID=out_full.
  - accept_ok = !out_full | AXIS_OUT_TREADY.
- Ready and selection:
  - AXIS_INx_TREADY = resetn & accept_ok & (input_select==x).
  - The unselected input's TREADY is always 0. Its TVALID is ignored and it may stall indefinitely.
- Transfers:
  - A handshake on the selected input loads TDATA/TLAST into the output register and sets out_full.
  - Otherwise, an output handshake clears out_full.
  - Input-to-output latency is 1 clock.
  - Full throughput of 1 beat/clk is sustained while AXIS_OUT_TREADY=1, including across a select switch.
- Group counting (on a selected-input handshake with TLAST=1):
  - If packet_counter < max(PACKETS_PER_GROUP,1): packet_counter+1.
  - Otherwise: packet_counter=1 and input_select flips.
  - The switch takes effect on the next clock. The first beat of the new input may transfer on that clock, with no bubble.
- Data rules:
  - TLAST is never generated or altered; the sink sees source packet boundaries unchanged.
  - TDATA is registered only on a handshake and holds stable while TVALID=1 and TREADY=0.
- Boundaries:
  - PACKETS_PER_GROUP changed mid-group: compared on the next TLAST. If the new value is ≤ the current count, the switch happens at that TLAST.
  - Simultaneous output drain and input load in the same clock: out_full stays 1 and the new beat replaces the old.
  - Both inputs valid: only the selected one is consumed.
  - Reset mid-packet: the output beat is dropped, selection returns to input 0 and the count to 1. Upstream is responsible for also being reset.

Optional Feature:
- Macro: PING_PONG_MERGER_PKT_CHECK_EN.
- Defined:
  - A beat counter 1..PACKET_SIZE/64 runs on accepted input beats.
  - PKT_ERR sets and stays set until reset in either case:
    - TLAST=1 arrives with count < PACKET_SIZE/64.
    - TLAST=0 arrives at count == PACKET_SIZE/64.
  - The counter resets to 1 on every accepted TLAST.
  - Data flow is never affected.
- Undefined: the counter is not built and PKT_ERR is tied to 0.

Test Plan:
- PPG=2, PACKET_SIZE=256, both inputs always valid with 4-beat packets, OUT_TREADY=1 -> output order 0,0,1,1,0,0; 1 beat/clk with no gap at the switches; TLAST on every 4th beat.
- PPG=0 -> behaves as PPG=1, alternating 0,1,0,1 per packet.
- Random OUT_TREADY (50%) -> no beat lost or duplicated; TDATA held stable while stalled; source order preserved (scoreboard against expected interleave).
- Input 1 valid with input 0 idle -> AXIS_IN1_TREADY stays 0 and no output until input 0 completes its group.
- resetn low for 1 clk mid-packet on input 1 -> next clock TVALID=0, both TREADY=0; afterwards the first accepted beat comes from input 0.
- With the macro: 3-beat packet (TLAST early) at PACKET_SIZE=256 -> PKT_ERR=1 the clock after that TLAST and stays set until reset. Without the macro: PKT_ERR stays 0.
